// File: rtl/ser_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ser_frame_tx_if
// Description : Parallel-word handshake and serial-line status bundle for
//               the serial frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ser_frame_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         busy;
  logic         done;

  // Word source / line observer side
  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  busy,
    input  done
  );

  // Transmitter side
  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/ser_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : ser_frame_tx
// Description : Serialises an N-bit word as start(0), N data bits LSB-first,
//               stop(1); every bit is held for DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_frame_tx #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  ser_frame_tx_if.slave bus
);

  // A baud counter must exist even when DIV=1, so its width never drops to 0.
  localparam int c_BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_BIT_W  = $clog2(N);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(DIV - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [c_BIT_W-1:0]  r_bit;
  logic [N-1:0]        r_buf;
  logic                r_sout;
  logic                r_done;

  state_t              w_state_nxt;
  logic [c_BAUD_W-1:0] w_baud_nxt;
  logic [c_BIT_W-1:0]  w_bit_nxt;
  logic [N-1:0]        w_buf_nxt;
  logic                w_sout_nxt;
  logic                w_done_nxt;
  logic                w_bit_end;

  // Last clock of the current bit period.
  assign w_bit_end = (r_baud == c_BAUD_LAST);

  // Next-state, counter and buffer logic; the line level is derived from the
  // state being entered so that sout is registered yet aligned with the state.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_buf_nxt   = r_buf;
    w_done_nxt  = 1'b0;
    w_sout_nxt  = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (bus.din_valid) begin
          w_buf_nxt   = bus.din;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          w_buf_nxt  = {1'b0, r_buf[N-1:1]};
          if (r_bit == c_BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + c_BIT_W'(1);
          end
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + c_BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START: w_sout_nxt = 1'b0;
      S_DATA:  w_sout_nxt = w_buf_nxt[0];
      default: w_sout_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_buf   <= '0;
      r_sout  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_buf   <= w_buf_nxt;
      r_sout  <= w_sout_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.din_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sout      = r_sout;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ser_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_frame_tx
// Description : Directed self-checking bench for ser_frame_tx (N=8/DIV=4 and
//               N=4/DIV=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_frame_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ser_frame_tx_if #(.N(8)) bus8();
  ser_frame_tx_if #(.N(4)) bus4();

  ser_frame_tx #(.N(8), .DIV(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  ser_frame_tx #(.N(4), .DIV(1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Status vectors: {sout, busy, din_ready, done}
  wire [3:0] st8 = {bus8.sout, bus8.busy, bus8.din_ready, bus8.done};
  wire [3:0] st4 = {bus4.sout, bus4.busy, bus4.din_ready, bus4.done};

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus8.din = 8'h00; bus8.din_valid = 1'b1;
    bus4.din = 4'hF;  bus4.din_valid = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (st8 !== 4'b1010) begin errors++; $display("FAIL reset8 cyc%0d: got %b want 1010", c, st8); end
      checks++;
      if (st4 !== 4'b1010) begin errors++; $display("FAIL reset4 cyc%0d: got %b want 1010", c, st4); end
    end
    reset = 1'b0;
    bus8.din_valid = 1'b0;
    bus4.din_valid = 1'b0;
    step();
    checks++;
    if (st8 !== 4'b1010) begin errors++; $display("FAIL reset8 release: got %b want 1010", st8); end
    checks++;
    if (st4 !== 4'b1010) begin errors++; $display("FAIL reset4 release: got %b want 1010", st4); end
  endtask

  task automatic test_single_frame();
    logic [9:0] bits;
    logic [3:0] exp;
    bits = 10'b1101001010;  // A5: start, 1,0,1,0,0,1,0,1, stop
    checks++;
    if (bus8.din_ready !== 1'b1) begin errors++; $display("FAIL single ready: got %b want 1", bus8.din_ready); end
    bus8.din = 8'hA5; bus8.din_valid = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      if (k == 1) bus8.din_valid = 1'b0;
      if (k <= 40)      exp = {bits[(k-1)/4], 3'b100};
      else if (k == 41) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if (st8 !== exp) begin errors++; $display("FAIL single T+%0d: got %b want %b", k, st8, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] b1, b2;
    logic [3:0] exp;
    b1 = 10'b1001111000;  // 3C
    b2 = 10'b1110000110;  // C3
    bus8.din = 8'h3C; bus8.din_valid = 1'b1;
    for (int k = 1; k <= 83; k++) begin
      step();
      if (k < 35)       bus8.din = (k % 2 == 1) ? 8'h55 : 8'hAA;
      else if (k <= 41) bus8.din = 8'hC3;
      else begin
        bus8.din = (k % 2 == 1) ? 8'h0F : 8'hF0;
        bus8.din_valid = 1'b0;
      end
      if (k <= 40)      exp = {b1[(k-1)/4], 3'b100};
      else if (k == 41) exp = 4'b1011;
      else if (k <= 81) exp = {b2[(k-42)/4], 3'b100};
      else if (k == 82) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if (st8 !== exp) begin errors++; $display("FAIL b2b T+%0d: got %b want %b", k, st8, exp); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    logic [3:0] exp;
    bits = 10'b1111111110;  // FF
    bus8.din = 8'h5A; bus8.din_valid = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 1) bus8.din_valid = 1'b0;
      if (k == 18) begin
        checks++;
        if (st8 !== 4'b1100) begin errors++; $display("FAIL midrst T+18: got %b want 1100", st8); end
        reset = 1'b1;
      end else if (k >= 19) begin
        reset = 1'b0;
        checks++;
        if (st8 !== 4'b1010) begin errors++; $display("FAIL midrst T+%0d: got %b want 1010", k, st8); end
      end
    end
    bus8.din = 8'hFF; bus8.din_valid = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      if (k == 1) bus8.din_valid = 1'b0;
      if (k <= 40)      exp = {bits[(k-1)/4], 3'b100};
      else if (k == 41) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if (st8 !== exp) begin errors++; $display("FAIL ff T+%0d: got %b want %b", k, st8, exp); end
    end
  endtask

  task automatic test_ignored_valid();
    logic [3:0] exp;
    bus8.din = 8'h96; bus8.din_valid = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 1) bus8.din_valid = 1'b0;
      if (k == 37) begin bus8.din = 8'h00; bus8.din_valid = 1'b1; end
      if (k == 40) bus8.din_valid = 1'b0;
      if (k >= 37) begin
        if (k <= 40)      exp = 4'b1100;
        else if (k == 41) exp = 4'b1011;
        else              exp = 4'b1010;
        checks++;
        if (st8 !== exp) begin errors++; $display("FAIL ignvalid T+%0d: got %b want %b", k, st8, exp); end
      end
    end
  endtask

  task automatic test_div1();
    logic [5:0] bits;
    logic [3:0] exp;
    bits = 6'b101100;  // 0,0,1,1,0,1 over T+1..T+6
    checks++;
    if (bus4.din_ready !== 1'b1) begin errors++; $display("FAIL div1 ready: got %b want 1", bus4.din_ready); end
    bus4.din = 4'b0110; bus4.din_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin bus4.din_valid = 1'b0; bus4.din = 4'b1001; end
      if (k <= 6)      exp = {bits[k-1], 3'b100};
      else if (k == 7) exp = 4'b1011;
      else             exp = 4'b1010;
      checks++;
      if (st4 !== exp) begin errors++; $display("FAIL div1 T+%0d: got %b want %b", k, st4, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_valid();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ser_frame_tx.md
# ser_frame_tx

Serial frame transmitter that sits directly downstream of the universal shift register. It accepts an N-bit parallel word (normally the register's `q`) through a valid/ready handshake and serialises it onto one line. The frame is a start bit (0), N data bits LSB-first, then a stop bit (1). Each bit is held for DIV clocks, so the block sets the line bit rate from the system clock.

## Interface
- `N`, 8: data word width; N >= 2.
- `DIV`, 4: clocks per serial bit; DIV >= 1.

- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  one clock; reset is synchronous and active-high.
- `din`  input  N  parallel word to send.
- `din_valid`  input  1  `din` is valid this cycle.
- `din_ready`  output  1  block can accept a word; high exactly when FSM is in IDLE.
- `sout`  output  1  serial line, registered; idles high.
- `busy`  output  1  high while a frame is in progress (states START/DATA/STOP).
- `done`  output  1  one-cycle pulse marking completion of a frame.

## Operation
- **Reset values**, while reset is high and in the cycle after it:
  - state IDLE, `sout`=1, `busy`=0, `done`=0, `din_ready`=1.
  - Baud counter and bit counter are 0.
  - A handshake is never accepted while `reset`=1.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE**
  - `sout`=1.
  - If `din_valid`=1 then `din` is latched into an internal N-bit shift buffer, the baud counter is cleared, and the next state is START.
  - Otherwise the FSM stays in IDLE.
- **START**
  - `sout`=0 for DIV cycles, then go to DATA with bit counter = 0.
- **DATA**
  - `sout` = buffer[0] for DIV cycles.
  - At the end of each bit period the buffer shifts right by one and the bit counter increments.
  - After bit N-1 completes, go to STOP.
- **STOP**
  - `sout`=1 for DIV cycles, then go to IDLE and pulse `done`.
- **Counters:**
  - Baud counter is ceil(log2(DIV)) bits wide, minimum 1; it counts 0..DIV-1 and wraps at each bit boundary.
  - Bit counter is ceil(log2(N)) bits wide and counts 0..N-1.
  - With DIV=1 every bit lasts exactly one cycle; no counter overflow is permitted.
- **Input latching:** `din` is sampled only at the accept cycle. Changes to `din` or `din_valid` during a frame are ignored.
- **`done` with a new accept:** `done` is asserted in the first IDLE cycle after STOP. If `din_valid`=1 in that same cycle, the next word is accepted in that cycle, so `done` and the accept coincide.
- **Reset mid-frame:**
  - The frame is abandoned and no `done` is produced.
  - On the next edge, `sout`=1 and state is IDLE.
  - The buffer contents are don't-care.

## Timing
- Accept at cycle T (state IDLE, `din_valid`=1, `reset`=0).
- Cycle numbering: cycle T+k is the k-th cycle after the accept edge.
- `busy`=1 and `din_ready`=0 from T+1 through T+(N+2)*DIV.
- Start bit: `sout`=0 during T+1 .. T+DIV.
- Data bit i: `sout`=din[i] during T+1+(i+1)*DIV .. T+(i+2)*DIV.
- Stop bit: `sout`=1 during T+1+(N+1)*DIV .. T+(N+2)*DIV.
- Completion: `done`=1 and `din_ready`=1 at T+(N+2)*DIV+1, for exactly one cycle.
- Maximum throughput: one frame per (N+2)*DIV+1 cycles. There is exactly one idle-high cycle between back-to-back frames.
- `din_ready` is combinational from state only and has no path from `din_valid`.

## Test plan
- **Reset values:** hold `reset` for 3 cycles with `din_valid`=1 -> no accept; `sout`=1, `busy`=0, `done`=0, `din_ready`=1 throughout and one cycle after release.
- **Single frame:** N=8, DIV=4, `din`=8'hA5 accepted at T -> `sout` shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (T+1..T+40). `done`=1 only at T+41.
- **Back-to-back and input latching:**
  - `din_valid` held high with 8'h3C then 8'hC3 -> second accept at T+41 coinciding with `done`.
  - Second frame starts at T+42 and carries 8'hC3.
  - Toggling `din` mid-frame does not alter the first frame.
- **Reset mid-frame:** assert `reset` at T+18 (DATA state) for 1 cycle -> `sout`=1, `busy`=0, `din_ready`=1 at T+19; no `done` pulse. A new 8'hFF then transmits correctly.
- **DIV=1, N=4:** `din`=4'b0110 at T -> `sout`=0,0,1,1,0,1 over T+1..T+6; `done` at T+7.
- **Ignored valid while busy:** pulse `din_valid` with 8'h00 during STOP -> not accepted; `din_ready` stays 0 until `done`, and the line stays idle-high afterwards.
